// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared definitions for the double-buffered frame store:
//                default pixel/raster geometry, a constant clog2 helper and
//                the bank identifier type.
//  Contents    : c_PIX_W, c_H_RES, c_V_RES, c_DEPTH, c_ADDR_W, clog2(),
//                bank_e
//  Revision    : 1.0  initial release
// ============================================================================
package fb_pkg;

   localparam int unsigned c_PIX_W = 4;
   localparam int unsigned c_H_RES = 320;
   localparam int unsigned c_V_RES = 240;

   // Returns at least 1 so a single-entry store still gets a 1-bit pointer.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((64'(1) << width) < 64'(value)) begin
         width++;
      end
      if (width == 0) begin
         width = 1;
      end
      return width;
   endfunction

   localparam int unsigned c_DEPTH  = c_H_RES * c_V_RES;
   localparam int unsigned c_ADDR_W = clog2(c_DEPTH);

   typedef enum logic [0:0] {
      BANK_0 = 1'b0,
      BANK_1 = 1'b1
   } bank_e;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/framebuffer_dbuf_if.sv
`default_nettype none
// ============================================================================
//  Module      : framebuffer_dbuf_if
//  Description : Writer / reader / swap bundle of the frame store.
//  Modports    : master - pixel source + scan-out + swap control side
//                slave  - the frame store itself
//  Signals     : wr_ptr_reset, wr_en, wr_data  -> store ; wr_ready,
//                wr_frame_done <- store ; rd_ptr_reset, rd_en -> store ;
//                rd_data, rd_valid, rd_frame_end <- store ; swap_req ->
//                store ; front_bank <- store
//  Revision    : 1.0  initial release
// ============================================================================
interface framebuffer_dbuf_if
   import fb_pkg::*;
#(
   parameter int unsigned PIX_W = c_PIX_W
);

   logic             wr_ptr_reset;
   logic             wr_en;
   logic [PIX_W-1:0] wr_data;
   logic             wr_ready;
   logic             wr_frame_done;
   logic             rd_ptr_reset;
   logic             rd_en;
   logic [PIX_W-1:0] rd_data;
   logic             rd_valid;
   logic             rd_frame_end;
   logic             swap_req;
   logic             front_bank;

   modport master (
      output wr_ptr_reset, wr_en, wr_data,
      output rd_ptr_reset, rd_en, swap_req,
      input  wr_ready, wr_frame_done,
      input  rd_data, rd_valid, rd_frame_end, front_bank
   );

   modport slave (
      input  wr_ptr_reset, wr_en, wr_data,
      input  rd_ptr_reset, rd_en, swap_req,
      output wr_ready, wr_frame_done,
      output rd_data, rd_valid, rd_frame_end, front_bank
   );

endinterface : framebuffer_dbuf_if
`default_nettype wire

// File: rtl/fb_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fb_bank_ram
//  Description : Simple dual-port pixel RAM, one write port and one
//                synchronous read port, read-first on address collision,
//                no reset on the array or the read register.
//  Ports       : clk      - clock
//                we_i     - write enable, waddr_i/wdata_i - write port
//                re_i     - read enable, raddr_i - read address
//                rdata_o  - registered read data, holds while re_i=0
//  Revision    : 1.0  initial release
// ============================================================================
module fb_bank_ram #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned ADDR_W = 4
) (
   input  wire logic              clk,
   input  wire logic              we_i,
   input  wire logic [ADDR_W-1:0] waddr_i,
   input  wire logic [DATA_W-1:0] wdata_i,
   input  wire logic              re_i,
   input  wire logic [ADDR_W-1:0] raddr_i,
   output      logic [DATA_W-1:0] rdata_o
);

   // The array spans the whole address space because the bank select is
   // concatenated above the pixel pointer; with a non-power-of-two frame the
   // top of each bank half is simply never addressed.
   localparam int unsigned c_WORDS = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [c_WORDS];

   // Both ports use non-blocking updates, so a same-address read returns the
   // value stored before this edge's write.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_o <= mem_q[raddr_i];
      end
   end

endmodule : fb_bank_ram
`default_nettype wire

// File: rtl/framebuffer_dbuf.sv
`default_nettype none
// ============================================================================
//  Module      : framebuffer_dbuf
//  Description : Double-buffered pixel store between the fractal pixel
//                stream (writer, fills the back bank) and the display
//                scan-out (reader, scans the front bank). Banks swap only on
//                a read-frame boundary. DOUBLE_BUF=0 collapses it to one
//                shared bank with independent pointers.
//  Ports       : clk   - clock, rising edge
//                rst_n - synchronous reset, active low
//                bus   - framebuffer_dbuf_if.slave (write, read, swap)
//  Revision    : 1.0  initial release
// ============================================================================
module framebuffer_dbuf
   import fb_pkg::*;
#(
   parameter int unsigned PIX_W      = c_PIX_W,
   parameter int unsigned H_RES      = c_H_RES,
   parameter int unsigned V_RES      = c_V_RES,
   parameter bit          DOUBLE_BUF = 1'b1,
   parameter bit          AUTO_SWAP  = 1'b0
) (
   input wire logic          clk,
   input wire logic          rst_n,
   framebuffer_dbuf_if.slave bus
);

   localparam int unsigned c_DEPTH  = H_RES * V_RES;
   localparam int unsigned c_ADDR_W = clog2(c_DEPTH);
   localparam int unsigned c_RAM_AW = c_ADDR_W + (DOUBLE_BUF ? 1 : 0);
   localparam logic [c_ADDR_W-1:0] c_LAST = c_ADDR_W'(c_DEPTH - 1);
   localparam logic [c_ADDR_W-1:0] c_ONE  = c_ADDR_W'(1);

   logic [c_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic                wr_frame_done_q;
   logic                rd_valid_q;
   logic                rd_frame_end_q;
   logic                rd_data_clr_q;

   logic                w_wr_acc;
   logic                w_wr_last;
   logic                w_rd_acc;
   logic                w_rd_last;
   logic                w_swap;
   logic                w_front;
   logic                w_back_full;
   logic [c_RAM_AW-1:0] w_wr_addr;
   logic [c_RAM_AW-1:0] w_rd_addr;
   logic [PIX_W-1:0]    w_ram_q;

   assign w_wr_acc  = bus.wr_en & ~w_back_full & ~bus.wr_ptr_reset;
   assign w_wr_last = w_wr_acc & (wr_ptr_q == c_LAST);
   assign w_rd_acc  = bus.rd_en & ~bus.rd_ptr_reset;
   assign w_rd_last = w_rd_acc & (rd_ptr_q == c_LAST);

   // ------------------------------------------------------------------------
   // Bank / swap control
   // ------------------------------------------------------------------------
   generate
      if (DOUBLE_BUF) begin : g_dbuf
         bank_e front_bank_q;
         logic  back_full_q;
         logic  swap_pending_q;

         // Swap either on the last read of the frame (that read still sees
         // the old bank, since the RAM samples the address before the flip)
         // or while the reader is parked at the frame start.
         assign w_swap = swap_pending_q & ~bus.rd_ptr_reset &
                         (w_rd_last | ((rd_ptr_q == '0) & ~w_rd_acc));

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               front_bank_q   <= BANK_0;
               back_full_q    <= 1'b0;
               swap_pending_q <= 1'b0;
            end else if (w_swap) begin
               front_bank_q   <= (front_bank_q == BANK_0) ? BANK_1 : BANK_0;
               back_full_q    <= 1'b0;
               swap_pending_q <= 1'b0;
            end else begin
               if (w_wr_last) begin
                  back_full_q <= 1'b1;
               end
               // A request is only honoured once the back bank is complete;
               // an early request is dropped rather than remembered.
               if (back_full_q & (bus.swap_req | AUTO_SWAP)) begin
                  swap_pending_q <= 1'b1;
               end
            end
         end

         assign w_front     = front_bank_q;
         assign w_back_full = back_full_q;
         assign w_wr_addr   = {~w_front, wr_ptr_q};
         assign w_rd_addr   = {w_front, rd_ptr_q};
      end else begin : g_sbuf
         logic w_unused_swap_req;

         assign w_unused_swap_req = bus.swap_req;
         assign w_swap            = 1'b0;
         assign w_front           = 1'b0;
         assign w_back_full       = 1'b0;
         assign w_wr_addr         = wr_ptr_q;
         assign w_rd_addr         = rd_ptr_q;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Pointer next-state
   // ------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (bus.wr_ptr_reset || w_swap) begin
         wr_ptr_d = '0;
      end else if (w_wr_acc) begin
         wr_ptr_d = (wr_ptr_q == c_LAST) ? '0 : wr_ptr_q + c_ONE;
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      if (bus.rd_ptr_reset) begin
         rd_ptr_d = '0;
      end else if (w_rd_acc) begin
         rd_ptr_d = (rd_ptr_q == c_LAST) ? '0 : rd_ptr_q + c_ONE;
      end
   end

   // ------------------------------------------------------------------------
   // Pointers and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         wr_frame_done_q <= 1'b0;
         rd_valid_q      <= 1'b0;
         rd_frame_end_q  <= 1'b0;
         rd_data_clr_q   <= 1'b1;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_frame_done_q <= w_wr_last;
         rd_valid_q      <= w_rd_acc;
         rd_frame_end_q  <= w_rd_last;
         if (w_rd_acc) begin
            rd_data_clr_q <= 1'b0;
         end
      end
   end

   // The RAM read register has no reset; rd_data is forced to zero from
   // reset until the first accepted read reloads it.
   fb_bank_ram #(
      .DATA_W (PIX_W),
      .ADDR_W (c_RAM_AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (w_wr_acc & rst_n),
      .waddr_i (w_wr_addr),
      .wdata_i (bus.wr_data),
      .re_i    (w_rd_acc & rst_n),
      .raddr_i (w_rd_addr),
      .rdata_o (w_ram_q)
   );

   assign bus.wr_ready      = ~w_back_full;
   assign bus.wr_frame_done = wr_frame_done_q;
   assign bus.rd_data       = rd_data_clr_q ? '0 : w_ram_q;
   assign bus.rd_valid      = rd_valid_q;
   assign bus.rd_frame_end  = rd_frame_end_q;
   assign bus.front_bank    = w_front;

endmodule : framebuffer_dbuf
`default_nettype wire

// File: tb/tb_framebuffer_dbuf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_framebuffer_dbuf
//  Description : Directed bench for framebuffer_dbuf on an 4x2 raster.
//                dut_a: double buffer, manual swap (table of per-cycle rows)
//                dut_b: single bank (read-first collision)
//                dut_c: double buffer, automatic swap (mid-frame reset)
//                Output word layout: {wr_ready, wr_frame_done, rd_valid,
//                rd_data[3:0], rd_frame_end, front_bank}
//  Revision    : 1.0  initial release
// ============================================================================
module tb_framebuffer_dbuf;

   typedef struct {
      string      name;
      logic       wpr;
      logic       we;
      logic [3:0] wd;
      logic       rpr;
      logic       re;
      logic       sreq;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   framebuffer_dbuf_if #(.PIX_W(4)) ifa ();
   framebuffer_dbuf_if #(.PIX_W(4)) ifb ();
   framebuffer_dbuf_if #(.PIX_W(4)) ifc ();

   framebuffer_dbuf #(.PIX_W(4), .H_RES(4), .V_RES(2), .DOUBLE_BUF(1'b1), .AUTO_SWAP(1'b0))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   framebuffer_dbuf #(.PIX_W(4), .H_RES(4), .V_RES(2), .DOUBLE_BUF(1'b0), .AUTO_SWAP(1'b0))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
   framebuffer_dbuf #(.PIX_W(4), .H_RES(4), .V_RES(2), .DOUBLE_BUF(1'b1), .AUTO_SWAP(1'b1))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

   function automatic logic [8:0] pk(input logic wrdy, input logic wfd, input logic rv,
                                     input logic [3:0] rd, input logic rfe, input logic fb);
      return {wrdy, wfd, rv, rd, rfe, fb};
   endfunction

   function automatic logic [8:0] oa();
      return {ifa.wr_ready, ifa.wr_frame_done, ifa.rd_valid, ifa.rd_data, ifa.rd_frame_end, ifa.front_bank};
   endfunction
   function automatic logic [8:0] ob();
      return {ifb.wr_ready, ifb.wr_frame_done, ifb.rd_valid, ifb.rd_data, ifb.rd_frame_end, ifb.front_bank};
   endfunction
   function automatic logic [8:0] oc();
      return {ifc.wr_ready, ifc.wr_frame_done, ifc.rd_valid, ifc.rd_data, ifc.rd_frame_end, ifc.front_bank};
   endfunction

   function automatic void add(input string n, input logic wpr, input logic we, input logic [3:0] wd,
                               input logic rpr, input logic re, input logic sreq, input logic [8:0] exp);
      vec_t v;
      v.name = n; v.wpr = wpr; v.we = we; v.wd = wd;
      v.rpr = rpr; v.re = re; v.sreq = sreq; v.exp = exp;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b  {wr_ready,wr_frame_done,rd_valid,rd_data,rd_frame_end,front_bank}",
                  name, act, exp);
      end
   endtask

   task automatic step_b(input logic wpr, input logic we, input logic [3:0] wd, input logic rpr, input logic re);
      ifb.wr_ptr_reset = wpr; ifb.wr_en = we; ifb.wr_data = wd;
      ifb.rd_ptr_reset = rpr; ifb.rd_en = re; ifb.swap_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic step_c(input logic wpr, input logic we, input logic [3:0] wd, input logic rpr, input logic re);
      ifc.wr_ptr_reset = wpr; ifc.wr_en = we; ifc.wr_data = wd;
      ifc.rd_ptr_reset = rpr; ifc.rd_en = re; ifc.swap_req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      ifa.wr_ptr_reset = 0; ifa.wr_en = 0; ifa.wr_data = 0; ifa.rd_ptr_reset = 0; ifa.rd_en = 0; ifa.swap_req = 0;
      ifb.wr_ptr_reset = 0; ifb.wr_en = 0; ifb.wr_data = 0; ifb.rd_ptr_reset = 0; ifb.rd_en = 0; ifb.swap_req = 0;
      ifc.wr_ptr_reset = 0; ifc.wr_en = 0; ifc.wr_data = 0; ifc.rd_ptr_reset = 0; ifc.rd_en = 0; ifc.swap_req = 0;

      // ---------------- table for dut_a ----------------
      // 1: fill back bank 1 with 0..7, swap with reader idle at 0, scan it
      for (int k = 0; k < 7; k++) add("t1_wr", 0, 1, 4'(k), 0, 0, 1, pk(1, 0, 0, 4'h0, 0, 0));
      add("t1_wr_last",      0, 1, 4'h7, 0, 0, 1, pk(0, 1, 0, 4'h0, 0, 0));
      // 2: ninth write while full is dropped (pending becomes set here)
      add("t2_drop_F",       0, 1, 4'hF, 0, 0, 1, pk(0, 0, 0, 4'h0, 0, 0));
      add("t1_swap",         0, 0, 4'h0, 0, 0, 0, pk(1, 0, 0, 4'h0, 0, 1));
      for (int k = 0; k < 8; k++) add("t1_rd", 0, 0, 4'h0, 0, 1, 0, pk(1, 0, 1, 4'(k), logic'(k == 7), 1));
      add("rd_hold",         0, 0, 4'h0, 0, 0, 0, pk(1, 0, 0, 4'h7, 0, 1));
      // 3: fill bank 0 with 8..F, request swap mid-scan at rd_ptr=3
      for (int k = 0; k < 7; k++) add("t3_wr", 0, 1, 4'(8 + k), 0, 0, 0, pk(1, 0, 0, 4'h7, 0, 1));
      add("t3_wr_last",      0, 1, 4'hF, 0, 0, 0, pk(0, 1, 0, 4'h7, 0, 1));
      add("t3_no_req",       0, 0, 4'h0, 0, 0, 0, pk(0, 0, 0, 4'h7, 0, 1));
      for (int k = 0; k < 3; k++) add("t3_rd", 0, 0, 4'h0, 0, 1, 0, pk(0, 0, 1, 4'(k), 0, 1));
      add("t3_req_at3",      0, 0, 4'h0, 0, 1, 1, pk(0, 0, 1, 4'h3, 0, 1));
      for (int k = 4; k < 7; k++) add("t3_front_held", 0, 0, 4'h0, 0, 1, 0, pk(0, 0, 1, 4'(k), 0, 1));
      add("t3_swap_at_end",  0, 0, 4'h0, 0, 1, 0, pk(1, 0, 1, 4'h7, 1, 0));
      add("t3_new_front",    0, 0, 4'h0, 0, 1, 0, pk(1, 0, 1, 4'h8, 0, 0));
      // 4: rd_ptr_reset with rd_en at rd_ptr=5; wr_ptr_reset mid-write
      for (int k = 1; k < 5; k++) add("t4_rd", 0, 0, 4'h0, 0, 1, 0, pk(1, 0, 1, 4'(8 + k), 0, 0));
      add("t4_rpr_with_en",  0, 0, 4'h0, 1, 1, 0, pk(1, 0, 0, 4'hC, 0, 0));
      add("t4_rd_at0",       0, 0, 4'h0, 0, 1, 0, pk(1, 0, 1, 4'h8, 0, 0));
      add("t4_wr",           0, 1, 4'h1, 0, 0, 0, pk(1, 0, 0, 4'h8, 0, 0));
      add("t4_wr",           0, 1, 4'h2, 0, 0, 0, pk(1, 0, 0, 4'h8, 0, 0));
      add("t4_wpr_with_en",  1, 1, 4'h5, 0, 0, 0, pk(1, 0, 0, 4'h8, 0, 0));
      add("t4_wr_at0",       0, 1, 4'h6, 0, 0, 0, pk(1, 0, 0, 4'h8, 0, 0));
      for (int k = 1; k < 7; k++) add("t4_fill", 0, 1, 4'(k), 0, 0, 0, pk(1, 0, 0, 4'h8, 0, 0));
      add("t4_fill_last",    0, 1, 4'h7, 0, 0, 0, pk(0, 1, 0, 4'h8, 0, 0));
      add("t4_req_rpr",      0, 0, 4'h0, 1, 0, 1, pk(0, 0, 0, 4'h8, 0, 0));
      add("t4_swap_suppr",   0, 0, 4'h0, 1, 0, 0, pk(0, 0, 0, 4'h8, 0, 0));
      add("t4_swap",         0, 0, 4'h0, 0, 0, 0, pk(1, 0, 0, 4'h8, 0, 1));
      add("t4_wpr_landed0",  0, 0, 4'h0, 0, 1, 0, pk(1, 0, 1, 4'h6, 0, 1));
      add("t4_rd_addr1",     0, 0, 4'h0, 0, 1, 0, pk(1, 0, 1, 4'h1, 0, 1));

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_a", oa(), pk(1, 0, 0, 4'h0, 0, 0));
      chk("reset_b", ob(), pk(1, 0, 0, 4'h0, 0, 0));
      chk("reset_c", oc(), pk(1, 0, 0, 4'h0, 0, 0));
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         ifa.wr_ptr_reset = tbl[i].wpr; ifa.wr_en = tbl[i].we; ifa.wr_data = tbl[i].wd;
         ifa.rd_ptr_reset = tbl[i].rpr; ifa.rd_en = tbl[i].re; ifa.swap_req = tbl[i].sreq;
         @(posedge clk); #1;
         chk($sformatf("%s[%0d]", tbl[i].name, i), oa(), tbl[i].exp);
      end
      ifa.wr_ptr_reset = 0; ifa.wr_en = 0; ifa.rd_ptr_reset = 0; ifa.rd_en = 0; ifa.swap_req = 0;

      // ---------------- 5: single bank, read-first collision ----------------
      step_b(0, 1, 4'h1, 0, 0);
      step_b(0, 1, 4'h2, 0, 0);
      step_b(0, 1, 4'h3, 0, 0);
      step_b(1, 0, 4'h0, 0, 0);
      step_b(0, 1, 4'h7, 0, 1); chk("t5_rf_addr0", ob(), pk(1, 0, 1, 4'h1, 0, 0));
      step_b(0, 1, 4'h8, 0, 1); chk("t5_rf_addr1", ob(), pk(1, 0, 1, 4'h2, 0, 0));
      step_b(0, 1, 4'hA, 0, 1); chk("t5_rf_addr2", ob(), pk(1, 0, 1, 4'h3, 0, 0));
      step_b(0, 0, 4'h0, 1, 0); chk("t5_rpr",      ob(), pk(1, 0, 0, 4'h3, 0, 0));
      step_b(0, 0, 4'h0, 0, 1); chk("t5_reread0",  ob(), pk(1, 0, 1, 4'h7, 0, 0));
      step_b(0, 0, 4'h0, 0, 1); chk("t5_reread1",  ob(), pk(1, 0, 1, 4'h8, 0, 0));
      step_b(0, 0, 4'h0, 0, 1); chk("t5_reread2",  ob(), pk(1, 0, 1, 4'hA, 0, 0));
      for (int k = 3; k < 7; k++) step_b(0, 1, 4'(k), 0, 0);
      step_b(0, 1, 4'h7, 0, 0); chk("t5_frame_no_full", ob(), pk(1, 1, 0, 4'hA, 0, 0));
      step_b(0, 1, 4'hE, 0, 0); chk("t5_wrap_ready",    ob(), pk(1, 0, 0, 4'hA, 0, 0));

      // ---------------- 6: auto swap, reset mid-frame ----------------
      for (int k = 0; k < 4; k++) step_c(0, 1, 4'h9, 0, 0);
      rst_n = 1'b0;
      step_c(0, 0, 4'h0, 0, 0); chk("t6_midframe_reset", oc(), pk(1, 0, 0, 4'h0, 0, 0));
      rst_n = 1'b1;
      for (int k = 0; k < 7; k++) step_c(0, 1, 4'(k + 1), 0, 0);
      chk("t6_not_full_yet", oc(), pk(1, 0, 0, 4'h0, 0, 0));
      step_c(0, 1, 4'h8, 0, 0); chk("t6_frame_done", oc(), pk(0, 1, 0, 4'h0, 0, 0));
      step_c(0, 0, 4'h0, 0, 0); chk("t6_pending",    oc(), pk(0, 0, 0, 4'h0, 0, 0));
      step_c(0, 0, 4'h0, 0, 0); chk("t6_auto_swap",  oc(), pk(1, 0, 0, 4'h0, 0, 1));
      for (int k = 0; k < 8; k++) begin
         step_c(0, 0, 4'h0, 0, 1);
         chk($sformatf("t6_rd%0d", k), oc(), pk(1, 0, 1, 4'(k + 1), logic'(k == 7), 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_framebuffer_dbuf
`default_nettype wire
